imem_fetch_ctrl: RTL and testbench
==================================

# imem_fetch_ctrl

Instruction-fetch controller that sequences the LEGv8 instruction memory. Holds the fetch PC, presents the word address to the instruction memory, waits a programmable number of cycles, and then captures the returned instruction. Each captured instruction is pushed, with its PC, into a small prefetch queue that drains to the decode stage over a valid/ready handshake. A branch redirect flushes the queue and restarts fetch at the new PC.

## Interface
- DEPTH, 4: prefetch queue entries; power of two, ≥2.
- MEM_LATENCY, 1: cycles an address is held before `imem_instr` is sampled; ≥1.
- RESET_PC, 64'h0: byte PC loaded at reset.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_addr  out  64  word index to instruction memory, `{2'b00, fetch_pc[63:2]}`.
- imem_instr  in  32  instruction word returned for `imem_addr`; combinational from memory.
- redirect  in  1  one-cycle pulse requesting a flush and restart.
- redirect_pc  in  64  byte target PC; bits [1:0] ignored.
- out_valid  out  1  queue head valid.
- out_ready  in  1  consumer accepts the head this cycle.
- out_instr  out  32  head instruction.
- out_pc  out  64  head byte PC (always 4-aligned).
- fetch_count  out  32  number of instructions pushed since reset; wraps modulo 2^32.

## Operation
- Registers:
  - `fetch_pc` (64).
  - `wait_cnt` (ceil-log2 of MEM_LATENCY, min 1 bit).
  - `state` ∈ {WAIT, FULL}.
  - Queue storage of DEPTH×{pc, instr}.
  - `rd_ptr`/`wr_ptr` (log2 DEPTH).
  - `count` (0..DEPTH).
- WAIT:
  - `wait_cnt` increments each cycle.
  - When `wait_cnt == MEM_LATENCY-1`, the sample point is reached:
    - If the queue has space (`count < DEPTH`, or `count == DEPTH` with a pop this cycle), push `{fetch_pc, imem_instr}`, set `fetch_pc += 4`, `wait_cnt <= 0`, and increment `fetch_count`.
    - Otherwise go to FULL.
- FULL:
  - `imem_addr` and `fetch_pc` are held.
  - On the first cycle with a pop, push `{fetch_pc, imem_instr}`, set `fetch_pc += 4`, `wait_cnt <= 0`, and go to WAIT.
  - The latency is not re-counted, because the address was stable throughout.
- Pop: `out_valid && out_ready` advances `rd_ptr` and decrements `count`.
- Simultaneous push and pop: `count` is unchanged and both pointers advance. This is legal at full and at empty+1.
- Pointers wrap modulo DEPTH. `fetch_pc` wraps modulo 2^64 with no error.
- Redirect has the highest priority over everything else in that cycle:
  - Set `count <= 0` and `rd_ptr <= wr_ptr`.
  - Set `fetch_pc <= {redirect_pc[63:2], 2'b00}`, `wait_cnt <= 0`, `state <= WAIT`.
  - Suppress any push in that cycle; `fetch_count` does not increment.
  - A pop handshake in the same cycle completes: the consumer keeps that instruction, and it is still discarded from the queue as part of the flush.
- `out_valid = (count != 0)`. `out_instr`/`out_pc` are the entry at `rd_ptr`. They are driven combinationally from the queue registers, with no path from `out_ready`.
- `imem_addr` is driven combinationally from `fetch_pc` only.

## Timing
- Reset values:
  - `fetch_pc = RESET_PC`, so `imem_addr = RESET_PC>>2`.
  - `state = WAIT`, `wait_cnt = 0`, `count = 0`, pointers = 0.
  - `out_valid = 0`, `out_instr = 0`, `out_pc = 0` (storage cleared), `fetch_count = 0`.
- Reset assertion mid-operation clears all state immediately (asynchronous); queued entries are lost.
- Fetch throughput: one push per MEM_LATENCY cycles while not full.
- First push occurs at the MEM_LATENCY-th rising edge after `rst_n` deasserts. `out_valid` rises after that edge.
- Redirect at edge N: the first push from the new PC occurs at edge N+MEM_LATENCY. `out_valid` is 0 between edge N and that push.
- With MEM_LATENCY=1 and `out_ready` held high, `out_valid` stays 1 every cycle after the first push.
- `redirect` while in FULL returns to WAIT immediately.
- `redirect` and a sample point in the same cycle: the old-PC word is dropped.

## Test plan
- Memory words 0..3 = 0x8B1F03E5, 0xF84000A4, 0x8B040086, 0xF80010A6; MEM_LATENCY=1; `out_ready=1` → `out_instr` sequence 8B1F03E5, F84000A4, 8B040086, F80010A6 with `out_pc` 0, 4, 8, 12 on consecutive cycles; `fetch_count=4` after the 4th push.
- `out_ready=0`, DEPTH=4 → `count` saturates at 4 and `imem_addr` freezes at 4. Raising `out_ready` for one cycle pops PC 0, pushes PC 16 the same cycle, and `count` stays 4.
- MEM_LATENCY=3, `out_ready=1` → pushes spaced exactly 3 cycles apart; first `out_valid` after the 3rd edge after reset.
- Pulse `redirect` with `redirect_pc=0x0B` while 3 entries are queued → `out_valid=0` next cycle; next head `out_pc=0x08`, `out_instr=0x8B040086`; `fetch_count` excludes the dropped sample.
- `redirect` coincident with a pop and a sample point → no push that cycle, `count=0`, and the next PC fetched is the redirect target.
- Assert `rst_n=0` asynchronously mid-stream → `out_valid` drops without waiting for a clock edge; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imem_fetch_ctrl : LEGv8 instruction fetch sequencer with prefetch queue
// Revision 1.0
// ---------------------------------------------------------------------------
module imem_fetch_ctrl #(
   parameter int          DEPTH       = 4,
   parameter int          MEM_LATENCY = 1,
   parameter logic [63:0] RESET_PC    = 64'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [63:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect,
   input  logic [63:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [63:0] out_pc,
   output logic [31:0] fetch_count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int WW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [WW-1:0] LAST_WAIT = WW'(MEM_LATENCY - 1);
   localparam logic [PW:0]   FULL_CNT  = (PW + 1)'(DEPTH);

   localparam logic [0:0] ST_WAIT = 1'b0;
   localparam logic [0:0] ST_FULL = 1'b1;

   logic [63:0]   fetch_pc_q,    fetch_pc_d;
   logic [WW-1:0] wait_cnt_q,    wait_cnt_d;
   logic [0:0]    state_q,       state_d;
   logic [PW-1:0] rd_ptr_q,      rd_ptr_d;
   logic [PW-1:0] wr_ptr_q,      wr_ptr_d;
   logic [PW:0]   count_q,       count_d;
   logic [31:0]   fetch_count_q, fetch_count_d;
   logic [63:0]   pc_mem_q    [DEPTH];
   logic [31:0]   instr_mem_q [DEPTH];

   logic pop;
   logic push;
   logic sample;
   logic space;
   logic unused_pc_lsbs;

   assign unused_pc_lsbs = ^redirect_pc[1:0];

   always_comb begin
      pop           = (count_q != '0) && out_ready;
      sample        = (state_q == ST_WAIT) && (wait_cnt_q == LAST_WAIT);
      space         = (count_q != FULL_CNT) || pop;
      push          = 1'b0;
      fetch_pc_d    = fetch_pc_q;
      wait_cnt_d    = wait_cnt_q;
      state_d       = state_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;
      fetch_count_d = fetch_count_q;

      if (redirect) begin
         // Flush wins over everything; a coincident pop is still honoured by the consumer.
         fetch_pc_d = {redirect_pc[63:2], 2'b00};
         wait_cnt_d = '0;
         state_d    = ST_WAIT;
         count_d    = '0;
         rd_ptr_d   = wr_ptr_q;
      end else begin
         case (state_q)
            ST_WAIT: begin
               if (sample) begin
                  if (space) push = 1'b1;
                  else       state_d = ST_FULL;
               end else begin
                  wait_cnt_d = wait_cnt_q + 1'b1;
               end
            end
            default: begin
               // Address was held stable while full, so the word is already valid.
               if (pop) begin
                  push    = 1'b1;
                  state_d = ST_WAIT;
               end
            end
         endcase

         if (push) begin
            fetch_pc_d    = fetch_pc_q + 64'd4;
            wait_cnt_d    = '0;
            wr_ptr_d      = wr_ptr_q + 1'b1;
            fetch_count_d = fetch_count_q + 32'd1;
         end
         if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q    <= RESET_PC;
         wait_cnt_q    <= '0;
         state_q       <= ST_WAIT;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         fetch_count_q <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         wait_cnt_q    <= wait_cnt_d;
         state_q       <= state_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]    <= '0;
            instr_mem_q[i] <= '0;
         end
      end else if (push) begin
         pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
         instr_mem_q[wr_ptr_q] <= imem_instr;
      end
   end

   assign imem_addr   = {2'b00, fetch_pc_q[63:2]};
   assign out_valid   = (count_q != '0);
   assign out_instr   = instr_mem_q[rd_ptr_q];
   assign out_pc      = pc_mem_q[rd_ptr_q];
   assign fetch_count = fetch_count_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// tb_imem_fetch_ctrl : directed self-checking bench, one DUT at MEM_LATENCY=1 and one at 3.
module tb_imem_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic [63:0] a_imem_addr, b_imem_addr;
   logic [31:0] a_imem_instr, b_imem_instr;
   logic        a_redirect = 1'b0;
   logic [63:0] a_redirect_pc = 64'h0;
   logic        a_out_valid, b_out_valid;
   logic        a_out_ready = 1'b1;
   logic        b_out_ready = 1'b1;
   logic [31:0] a_out_instr, b_out_instr;
   logic [63:0] a_out_pc, b_out_pc;
   logic [31:0] a_fetch_count, b_fetch_count;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      case (a)
         64'd0:   return 32'h8B1F03E5;
         64'd1:   return 32'hF84000A4;
         64'd2:   return 32'h8B040086;
         64'd3:   return 32'hF80010A6;
         default: return {16'hC0DE, a[15:0]};
      endcase
   endfunction

   assign a_imem_instr = mem_word(a_imem_addr);
   assign b_imem_instr = mem_word(b_imem_addr);

   imem_fetch_ctrl #(.DEPTH(4), .MEM_LATENCY(1), .RESET_PC(64'h0)) u_dut_a (
      .clk(clk), .rst_n(rst_n),
      .imem_addr(a_imem_addr), .imem_instr(a_imem_instr),
      .redirect(a_redirect), .redirect_pc(a_redirect_pc),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_instr(a_out_instr), .out_pc(a_out_pc),
      .fetch_count(a_fetch_count)
   );

   imem_fetch_ctrl #(.DEPTH(4), .MEM_LATENCY(3), .RESET_PC(64'h0)) u_dut_b (
      .clk(clk), .rst_n(rst_n),
      .imem_addr(b_imem_addr), .imem_instr(b_imem_instr),
      .redirect(1'b0), .redirect_pc(64'h0),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_instr(b_out_instr), .out_pc(b_out_pc),
      .fetch_count(b_fetch_count)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   logic [31:0] exp_instr [4] = '{32'h8B1F03E5, 32'hF84000A4, 32'h8B040086, 32'hF80010A6};

   initial begin
      #2;
      check("rst_a_valid", 64'(a_out_valid), 64'd0);
      check("rst_a_instr", 64'(a_out_instr), 64'd0);
      check("rst_a_pc",    a_out_pc,         64'd0);
      check("rst_a_addr",  a_imem_addr,      64'd0);
      check("rst_a_fcnt",  64'(a_fetch_count), 64'd0);
      check("rst_b_valid", 64'(b_out_valid), 64'd0);

      @(negedge clk);
      rst_n = 1'b1;

      // Streaming with out_ready high on both instances.
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         check("a_stream_valid", 64'(a_out_valid), 64'd1);
         check("a_stream_pc",    a_out_pc,         64'(4 * (k - 1)));
         if (k <= 4) begin
            check("a_stream_instr", 64'(a_out_instr), 64'(exp_instr[k-1]));
            check("a_stream_fcnt",  64'(a_fetch_count), 64'(k));
         end
         check("b_lat3_valid", 64'(b_out_valid), (k % 3 == 0) ? 64'd1 : 64'd0);
         check("b_lat3_fcnt",  64'(b_fetch_count), 64'(k / 3));
         if (k == 6) check("b_lat3_pc", b_out_pc, 64'd4);
      end

      // Asynchronous reset between clock edges.
      #2;
      rst_n = 1'b0;
      #1;
      check("async_a_valid", 64'(a_out_valid), 64'd0);
      check("async_b_valid", 64'(b_out_valid), 64'd0);
      check("async_a_fcnt",  64'(a_fetch_count), 64'd0);
      check("async_a_addr",  a_imem_addr, 64'd0);
      a_out_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Backpressure: four pushes then FULL with address frozen at word 4.
      repeat (5) @(negedge clk);
      check("full_valid", 64'(a_out_valid), 64'd1);
      check("full_pc",    a_out_pc,         64'd0);
      check("full_addr",  a_imem_addr,      64'd4);
      check("full_fcnt",  64'(a_fetch_count), 64'd4);

      a_out_ready = 1'b1;
      @(negedge clk);
      a_out_ready = 1'b0;
      check("full_pop_pc",   a_out_pc,           64'd4);
      check("full_pop_fcnt", 64'(a_fetch_count), 64'd5);
      check("full_pop_addr", a_imem_addr,        64'd5);

      @(negedge clk);
      check("still_full_fcnt", 64'(a_fetch_count), 64'd5);
      check("still_full_addr", a_imem_addr,        64'd5);

      // Redirect while FULL.
      a_redirect = 1'b1;
      a_redirect_pc = 64'h8;
      @(negedge clk);
      a_redirect = 1'b0;
      check("redir_full_valid", 64'(a_out_valid), 64'd0);
      check("redir_full_addr",  a_imem_addr,      64'd2);
      check("redir_full_fcnt",  64'(a_fetch_count), 64'd5);
      @(negedge clk);
      check("redir_full_hpc",   a_out_pc,           64'd8);
      check("redir_full_hins",  64'(a_out_instr),   64'h8B040086);
      check("redir_full_fcnt2", 64'(a_fetch_count), 64'd6);
      repeat (2) @(negedge clk);
      check("q3_fcnt", 64'(a_fetch_count), 64'd8);
      check("q3_addr", a_imem_addr,        64'd5);
      check("q3_pc",   a_out_pc,           64'd8);

      // Redirect coincident with pop and a sample point, unaligned target.
      a_redirect = 1'b1;
      a_redirect_pc = 64'h0B;
      a_out_ready = 1'b1;
      @(negedge clk);
      a_redirect = 1'b0;
      a_out_ready = 1'b0;
      check("redir_valid", 64'(a_out_valid), 64'd0);
      check("redir_fcnt",  64'(a_fetch_count), 64'd8);
      check("redir_addr",  a_imem_addr, 64'd2);
      @(negedge clk);
      check("redir_hvalid", 64'(a_out_valid), 64'd1);
      check("redir_hpc",    a_out_pc,         64'd8);
      check("redir_hins",   64'(a_out_instr), 64'h8B040086);
      check("redir_fcnt2",  64'(a_fetch_count), 64'd9);
      a_out_ready = 1'b1;
      @(negedge clk);
      check("drain_pc",  a_out_pc,         64'd12);
      check("drain_ins", 64'(a_out_instr), 64'hF80010A6);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
